// File: rtl/cpu_types_pkg.sv
// Shared CPU cache types: icache FSM states and default 16-frame geometry.
package cpu_types_pkg;

    localparam int unsigned IIDX_W = 4;
    localparam int unsigned ITAG_W = 30 - IIDX_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        logic [31:0]       data;
    } icache_frame_t;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped frame storage: asynchronous read, single write port, resettable valids.
module icache_array #(
    parameter int unsigned NFRAMES = 16
) (
    input  logic                              CLK,
    input  logic                              nRST,
    input  logic [$clog2(NFRAMES)-1:0]        rd_idx,
    output logic                              rd_valid,
    output logic [30-$clog2(NFRAMES)-1:0]     rd_tag,
    output logic [31:0]                       rd_data,
    input  logic                              wr_en,
    input  logic [$clog2(NFRAMES)-1:0]        wr_idx,
    input  logic [30-$clog2(NFRAMES)-1:0]     wr_tag,
    input  logic [31:0]                       wr_data
);
    localparam int unsigned IDX_W = $clog2(NFRAMES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic [NFRAMES-1:0] valid;
    logic [TAG_W-1:0]   tags [NFRAMES];
    logic [31:0]        data [NFRAMES];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tags and data carry no reset; valid gates their use.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only, one-word-block instruction cache between fetch and memory arbiter.
module icache
    import cpu_types_pkg::*;
#(
    parameter int unsigned NFRAMES = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dp_iREN,
    input  logic [31:0] dp_imemaddr,
    output logic        dp_ihit,
    output logic [31:0] dp_imemload,
    output logic        mem_iREN,
    output logic [31:0] mem_iaddr,
    input  logic        mem_iwait,
    input  logic [31:0] mem_iload
);
    localparam int unsigned IDX_W = $clog2(NFRAMES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    icache_state_t    state;
    logic [31:0]      miss_addr;

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_addr_tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             lookup_hit;
    logic             fill_done;
    logic             unused_offset;

    assign rd_idx        = dp_imemaddr[IDX_W+1:2];
    assign rd_addr_tag   = dp_imemaddr[31:IDX_W+2];
    assign unused_offset = ^{dp_imemaddr[1:0], miss_addr[1:0]};

    icache_array #(
        .NFRAMES (NFRAMES)
    ) u_array (
        .CLK      (CLK),
        .nRST     (nRST),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill_done),
        .wr_idx   (miss_addr[IDX_W+1:2]),
        .wr_tag   (miss_addr[31:IDX_W+2]),
        .wr_data  (mem_iload)
    );

    // Lookups are only honoured in IDLE; a request arriving as a fill completes waits a cycle.
    assign lookup_hit = (state == IDLE) && dp_iREN && rd_valid && (rd_tag == rd_addr_tag);
    assign fill_done  = (state == FILL) && !mem_iwait;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            miss_addr <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (dp_iREN && !lookup_hit) begin
                        state     <= FILL;
                        miss_addr <= dp_imemaddr;
                    end
                end
                FILL: begin
                    if (!mem_iwait) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory-side outputs decode the state register only, so they stay stable across a fill.
    always_comb begin
        dp_ihit     = 1'b0;
        dp_imemload = 32'h0;
        mem_iREN    = 1'b0;
        mem_iaddr   = 32'h0;
        if (state == FILL) begin
            mem_iREN  = 1'b1;
            mem_iaddr = miss_addr;
        end else if (lookup_hit) begin
            dp_ihit     = 1'b1;
            dp_imemload = rd_data;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed, table-driven bench for icache: per-cycle vectors plus a reset-during-fill sequence.
module tb_icache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dp_iREN;
    logic [31:0] dp_imemaddr;
    logic        dp_ihit;
    logic [31:0] dp_imemload;
    logic        mem_iREN;
    logic [31:0] mem_iaddr;
    logic        mem_iwait;
    logic [31:0] mem_iload;

    int checks = 0;
    int errors = 0;

    icache #(
        .NFRAMES (16)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .dp_iREN     (dp_iREN),
        .dp_imemaddr (dp_imemaddr),
        .dp_ihit     (dp_ihit),
        .dp_imemload (dp_imemload),
        .mem_iREN    (mem_iREN),
        .mem_iaddr   (mem_iaddr),
        .mem_iwait   (mem_iwait),
        .mem_iload   (mem_iload)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ren;
        logic [31:0] addr;
        logic        iwait;
        logic [31:0] iload;
        logic        hit;
        logic [31:0] load;
        logic        mren;
        logic [31:0] maddr;
    } vec_t;

    localparam int NVEC = 28;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic hit, input logic [31:0] load,
                              input logic mren, input logic [31:0] maddr);
        check({tag, " dp_ihit"},     32'(dp_ihit),  32'(hit));
        check({tag, " dp_imemload"}, dp_imemload,   load);
        check({tag, " mem_iREN"},    32'(mem_iREN), 32'(mren));
        check({tag, " mem_iaddr"},   mem_iaddr,     maddr);
    endtask

    initial begin
        // ren addr iwait iload | hit load mren maddr  (one entry per clock cycle)
        // Cold miss on 0x0 with two wait cycles, then hits.
        vecs[0]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0,           1'b0, 32'h0,           1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0,           1'b0, 32'h0,           1'b1, 32'h0};
        vecs[2]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0,           1'b0, 32'h0,           1'b1, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0000, 1'b0, 32'h8C01_0004,   1'b0, 32'h0,           1'b1, 32'h0};
        vecs[4]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0,           1'b1, 32'h8C01_0004,   1'b0, 32'h0};
        vecs[5]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0,           1'b1, 32'h8C01_0004,   1'b0, 32'h0};
        // Idle request suppresses everything.
        vecs[6]  = '{1'b0, 32'h0000_0000, 1'b1, 32'h0,           1'b0, 32'h0,           1'b0, 32'h0};
        // Conflict eviction on index 1.
        vecs[7]  = '{1'b1, 32'h0000_0004, 1'b1, 32'h0,           1'b0, 32'h0,           1'b0, 32'h0};
        vecs[8]  = '{1'b1, 32'h0000_0004, 1'b0, 32'h1111_1111,   1'b0, 32'h0,           1'b1, 32'h4};
        vecs[9]  = '{1'b1, 32'h0000_0004, 1'b1, 32'h0,           1'b1, 32'h1111_1111,   1'b0, 32'h0};
        vecs[10] = '{1'b1, 32'h0000_0044, 1'b1, 32'h0,           1'b0, 32'h0,           1'b0, 32'h0};
        vecs[11] = '{1'b1, 32'h0000_0044, 1'b0, 32'h2222_2222,   1'b0, 32'h0,           1'b1, 32'h44};
        vecs[12] = '{1'b1, 32'h0000_0044, 1'b1, 32'h0,           1'b1, 32'h2222_2222,   1'b0, 32'h0};
        vecs[13] = '{1'b1, 32'h0000_0004, 1'b1, 32'h0,           1'b0, 32'h0,           1'b0, 32'h0};
        vecs[14] = '{1'b1, 32'h0000_0004, 1'b0, 32'h3333_3333,   1'b0, 32'h0,           1'b1, 32'h4};
        vecs[15] = '{1'b1, 32'h0000_0004, 1'b1, 32'h0,           1'b1, 32'h3333_3333,   1'b0, 32'h0};
        vecs[16] = '{1'b1, 32'h0000_0000, 1'b1, 32'h0,           1'b1, 32'h8C01_0004,   1'b0, 32'h0};
        // Address changes and request drops mid-fill; fill still lands at 0x10.
        vecs[17] = '{1'b1, 32'h0000_0010, 1'b1, 32'h0,           1'b0, 32'h0,           1'b0, 32'h0};
        vecs[18] = '{1'b1, 32'h0000_0020, 1'b1, 32'h0,           1'b0, 32'h0,           1'b1, 32'h10};
        vecs[19] = '{1'b0, 32'h0000_0020, 1'b0, 32'h4444_4444,   1'b0, 32'h0,           1'b1, 32'h10};
        vecs[20] = '{1'b1, 32'h0000_0010, 1'b1, 32'h0,           1'b1, 32'h4444_4444,   1'b0, 32'h0};
        vecs[21] = '{1'b1, 32'h0000_0020, 1'b1, 32'h0,           1'b0, 32'h0,           1'b0, 32'h0};
        vecs[22] = '{1'b1, 32'h0000_0020, 1'b0, 32'h5555_5555,   1'b0, 32'h0,           1'b1, 32'h20};
        vecs[23] = '{1'b1, 32'h0000_0020, 1'b1, 32'h0,           1'b1, 32'h5555_5555,   1'b0, 32'h0};
        // Top frame, all-ones tag; byte offset ignored on lookup.
        vecs[24] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0,           1'b0, 32'h0,           1'b0, 32'h0};
        vecs[25] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 32'hDEAD_BEEF,   1'b0, 32'h0,           1'b1, 32'hFFFF_FFFC};
        vecs[26] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0,           1'b1, 32'hDEAD_BEEF,   1'b0, 32'h0};
        vecs[27] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0,           1'b1, 32'hDEAD_BEEF,   1'b0, 32'h0};

        nRST        = 1'b0;
        dp_iREN     = 1'b0;
        dp_imemaddr = 32'h0;
        mem_iwait   = 1'b1;
        mem_iload   = 32'h0;
        #3;
        check_outs("reset idle", 1'b0, 32'h0, 1'b0, 32'h0);
        dp_iREN = 1'b1;
        #1;
        check_outs("reset req", 1'b0, 32'h0, 1'b0, 32'h0);
        dp_iREN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge CLK);
            dp_iREN     = vecs[i].ren;
            dp_imemaddr = vecs[i].addr;
            mem_iwait   = vecs[i].iwait;
            mem_iload   = vecs[i].iload;
            #1;
            check_outs($sformatf("v%0d", i), vecs[i].hit, vecs[i].load, vecs[i].mren, vecs[i].maddr);
        end

        // Reset during a fill: request drops immediately, frame not written, valids cleared.
        @(negedge CLK);
        dp_iREN     = 1'b1;
        dp_imemaddr = 32'h0000_0030;
        mem_iwait   = 1'b1;
        #1;
        check_outs("rst seq miss", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge CLK);
        #1;
        check_outs("rst seq fill", 1'b0, 32'h0, 1'b1, 32'h30);
        #1;
        nRST = 1'b0;
        #1;
        check_outs("rst seq async", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge CLK);
        dp_iREN     = 1'b0;
        mem_iwait   = 1'b0;
        mem_iload   = 32'h7777_7777;
        nRST        = 1'b1;
        @(negedge CLK);
        dp_iREN     = 1'b1;
        dp_imemaddr = 32'h0000_0010;
        mem_iwait   = 1'b1;
        #1;
        check_outs("post rst 0x10 miss", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge CLK);
        dp_imemaddr = 32'h0000_0030;
        #1;
        check_outs("post rst 0x10 fill", 1'b0, 32'h0, 1'b1, 32'h10);
        mem_iwait = 1'b0;
        mem_iload = 32'h6666_6666;
        @(negedge CLK);
        mem_iwait = 1'b1;
        #1;
        check_outs("post rst 0x30 miss", 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge CLK);
        dp_imemaddr = 32'h0000_0010;
        #1;
        check_outs("post rst 0x30 fill", 1'b0, 32'h0, 1'b1, 32'h30);
        mem_iwait = 1'b0;
        mem_iload = 32'h8888_8888;
        @(negedge CLK);
        mem_iwait = 1'b1;
        #1;
        check_outs("post rst 0x10 hit", 1'b1, 32'h6666_6666, 1'b0, 32'h0);
        dp_imemaddr = 32'h0000_0030;
        #1;
        check_outs("post rst 0x30 hit", 1'b1, 32'h8888_8888, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
